// File: rtl/debug_port_gen2_if.sv
// Host and CPU side signal bundle for debug_port_gen2.
// The slave modport is the debug port; master is whoever drives the host strobes and CPU controls.
interface debug_port_gen2_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NSRC   = 4,
    parameter int SRC_W  = $clog2(NSRC)
);
    logic [7:0]             DEBUG_DIN;
    logic [7:0]             DEBUG_DOUT;
    logic [2:0]             DEBUG_ADDR;
    logic                   DEBUG_RD;
    logic                   DEBUG_WR;
    logic [ADDR_W-1:0]      DEBUG_MEM_ADDR;
    logic [DATA_W-1:0]      DEBUG_MEM_DATA_OUT;
    logic                   DEBUG_ADDR_INCX;
    logic                   DEBUG_ADDR_LDX;
    logic                   DEBUG_DOUT_LDX;
    logic [SRC_W-1:0]       DEBUG_DATAX;
    logic [NSRC*DATA_W-1:0] DEBUG_SRC_DATA;
    logic [2:0]             DEBUG_OPX;
    logic [3:0]             DEBUG_ARGX;
    logic                   DEBUG_REQX;
    logic                   DEBUG_ACKX;

    modport master (
        output DEBUG_DIN, DEBUG_ADDR, DEBUG_RD, DEBUG_WR,
        output DEBUG_ADDR_INCX, DEBUG_ADDR_LDX, DEBUG_DOUT_LDX, DEBUG_DATAX, DEBUG_SRC_DATA, DEBUG_ACKX,
        input  DEBUG_DOUT, DEBUG_MEM_ADDR, DEBUG_MEM_DATA_OUT, DEBUG_OPX, DEBUG_ARGX, DEBUG_REQX
    );

    modport slave (
        input  DEBUG_DIN, DEBUG_ADDR, DEBUG_RD, DEBUG_WR,
        input  DEBUG_ADDR_INCX, DEBUG_ADDR_LDX, DEBUG_DOUT_LDX, DEBUG_DATAX, DEBUG_SRC_DATA, DEBUG_ACKX,
        output DEBUG_DOUT, DEBUG_MEM_ADDR, DEBUG_MEM_DATA_OUT, DEBUG_OPX, DEBUG_ARGX, DEBUG_REQX
    );
endinterface

// File: rtl/debug_port_gen2.sv
// Byte-wide host debug port: synchronised host strobes, MA/MD lane registers, op request handshake.
// Optional macro DEBUG_STREAM_EN reissues RD_MEM/RD_REG ops when the host finishes reading MD.
module debug_port_gen2 #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int NSRC      = 4,
    parameter int ADDR_STEP = 2
) (
    input logic              CLK,
    input logic              RESET,
    debug_port_gen2_if.slave bus
);
    localparam int MA_LANES = ADDR_W / 8;
    localparam int MD_LANES = DATA_W / 8;
    localparam logic [2:0] DEBUG_OPX_NONE   = 3'd0;
    localparam logic [2:0] DEBUG_OPX_RD_MEM = 3'd1;
    localparam logic [2:0] DEBUG_OPX_RD_REG = 3'd3;
`ifdef DEBUG_STREAM_EN
    localparam logic STREAM = 1'b1;
`else
    localparam logic STREAM = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ma;
    logic [DATA_W-1:0] md;
    logic [2:0]        sel;
    logic              overrun;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [2:0]        opx;
    logic [3:0]        argx;

    logic wr_p0, wr_p1, wr_p2, rd_p0, rd_p1, rd_p2;
    logic vld_p0, vld_p1;
    logic wr_arm, rd_arm;
    logic wr_rise_p3, rd_fall_p3;

    logic [7:0]        ma_lane, md_lane, status, dout;
    logic [DATA_W-1:0] src_data;
    logic [2:0]        sel_ma_next, sel_md_next;

    // p0/p1 synchronise, p2 is history for edge detection; vld marks sync contents as real after reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_p0      <= 1'b0;
            wr_p1      <= 1'b0;
            wr_p2      <= 1'b0;
            rd_p0      <= 1'b0;
            rd_p1      <= 1'b0;
            rd_p2      <= 1'b0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            wr_arm     <= 1'b0;
            rd_arm     <= 1'b0;
            wr_rise_p3 <= 1'b0;
            rd_fall_p3 <= 1'b0;
        end else begin
            wr_p0      <= bus.DEBUG_WR;
            wr_p1      <= wr_p0;
            wr_p2      <= wr_p1;
            rd_p0      <= bus.DEBUG_RD;
            rd_p1      <= rd_p0;
            rd_p2      <= rd_p1;
            vld_p0     <= 1'b1;
            vld_p1     <= vld_p0;
            wr_arm     <= wr_arm | (vld_p1 & ~wr_p1);
            rd_arm     <= rd_arm | (vld_p1 & ~rd_p1);
            // p3: registered edge pulse, acted upon at the next edge
            wr_rise_p3 <= wr_arm & wr_p1 & ~wr_p2;
            rd_fall_p3 <= rd_arm & ~rd_p1 & rd_p2;
        end
    end

    always_comb begin
        ma_lane  = '0;
        md_lane  = '0;
        src_data = '0;
        for (int i = 0; i < MA_LANES; i++)
            if (sel == 3'(i)) ma_lane = ma[i*8 +: 8];
        for (int i = 0; i < MD_LANES; i++)
            if (sel == 3'(i)) md_lane = md[i*8 +: 8];
        for (int k = 0; k < NSRC; k++)
            if (int'(bus.DEBUG_DATAX) == k) src_data = bus.DEBUG_SRC_DATA[k*DATA_W +: DATA_W];
        sel_ma_next = (int'(sel) >= MA_LANES - 1) ? 3'd0 : sel + 3'd1;
        sel_md_next = (int'(sel) >= MD_LANES - 1) ? 3'd0 : sel + 3'd1;
        status = {state == S_REQ, overrun, STREAM, 2'b00, sel};
        dout   = '0;
        if (bus.DEBUG_RD) begin
            case (bus.DEBUG_ADDR)
                3'd0:    dout = status;
                3'd1:    dout = ma_lane;
                3'd2:    dout = md_lane;
                3'd3:    dout = {5'b0, sel};
                default: dout = '0;
            endcase
        end
    end

    // p4: register actions, op handshake FSM and CPU-side counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            ma       <= '0;
            md       <= '0;
            sel      <= '0;
            overrun  <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            opx      <= DEBUG_OPX_NONE;
            argx     <= '0;
        end else begin
            if (state == S_REQ && bus.DEBUG_ACKX) state <= S_IDLE;

            if (wr_rise_p3) begin
                case (bus.DEBUG_ADDR)
                    3'd0: begin
                        if (state == S_REQ) begin
                            overrun <= 1'b1;
                        end else begin
                            opx  <= bus.DEBUG_DIN[2:0];
                            argx <= bus.DEBUG_DIN[7:4];
                            if (bus.DEBUG_DIN[2:0] != DEBUG_OPX_NONE) state <= S_REQ;
                        end
                    end
                    3'd1: begin
                        for (int i = 0; i < MA_LANES; i++)
                            if (sel == 3'(i)) ma[i*8 +: 8] <= bus.DEBUG_DIN;
                        sel <= sel_ma_next;
                    end
                    3'd2: begin
                        for (int i = 0; i < MD_LANES; i++)
                            if (sel == 3'(i)) md[i*8 +: 8] <= bus.DEBUG_DIN;
                        sel <= sel_md_next;
                    end
                    3'd3:    sel <= bus.DEBUG_DIN[2:0];
                    default: ;
                endcase
            end

            if (rd_fall_p3) begin
                case (bus.DEBUG_ADDR)
                    3'd0: overrun <= 1'b0;
                    3'd1: sel <= sel_ma_next;
                    3'd2: begin
                        sel <= sel_md_next;
`ifdef DEBUG_STREAM_EN
                        if (sel_md_next == 3'd0 && state == S_IDLE &&
                            (opx == DEBUG_OPX_RD_MEM || opx == DEBUG_OPX_RD_REG))
                            state <= S_REQ;
`endif
                    end
                    default: ;
                endcase
            end

            // CPU capture overrides a host MD lane write on the same edge
            if (bus.DEBUG_DOUT_LDX) md <= src_data;

            if (bus.DEBUG_ADDR_LDX) begin
                mem_addr <= ma;
                mem_data <= md;
            end else if (bus.DEBUG_ADDR_INCX) begin
                mem_addr <= mem_addr + ADDR_W'(ADDR_STEP);
            end
        end
    end

    assign bus.DEBUG_DOUT         = dout;
    assign bus.DEBUG_MEM_ADDR     = mem_addr;
    assign bus.DEBUG_MEM_DATA_OUT = mem_data;
    assign bus.DEBUG_OPX          = opx;
    assign bus.DEBUG_ARGX         = argx;
    assign bus.DEBUG_REQX         = (state == S_REQ);
endmodule
